// File: rtl/aes128_mode_ctrl_if.sv
// Handshake bundle around aes128_mode_ctrl: plaintext input stream, result
// output stream and the cipher-core start/complete interface.
//   slave  : the mode controller's view (accepts din, produces dout, drives core)
//   master : the environment's view (block source, result sink, cipher core)
// Signals:
//   in_valid/in_ready/din     input block handshake and payload
//   out_valid/out_ready/dout  result handshake and payload
//   core_start/core_din       start pulse and input block to the cipher core
//   core_ready/core_dout      core idle/complete flag and core result
interface aes128_mode_ctrl_if;
  localparam int unsigned BLK_W = 128;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] din;

  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] dout;

  logic             core_start;
  logic [BLK_W-1:0] core_din;
  logic             core_ready;
  logic [BLK_W-1:0] core_dout;

  modport slave (
    input  in_valid,
    output in_ready,
    input  din,
    output out_valid,
    input  out_ready,
    output dout,
    output core_start,
    output core_din,
    input  core_ready,
    input  core_dout
  );

  modport master (
    output in_valid,
    input  in_ready,
    output din,
    input  out_valid,
    output out_ready,
    input  dout,
    input  core_start,
    input  core_din,
    output core_ready,
    output core_dout
  );
endinterface

// File: rtl/aes128_mode_ctrl.sv
// Block-mode sequencer in front of an AES-128 cipher core (ECB, CBC, CFB-128,
// OFB, CTR encryption). One block in flight: accept, form the core input,
// pulse core start, wait for completion, apply the mode post-XOR and chaining
// update, then hold the result until the sink takes it.
// Ports:
//   clk_sys, rst_n  clock, asynchronous active-low reset
//   mode            block mode (0 ECB,1 CBC,2 CFB,3 OFB,4 CTR, 5-7 as ECB), taken on iv_load
//   iv_load, iv     load chain register/mode, clear blk_cnt and err (IDLE only)
//   bus             input/output streams and cipher-core handshake (slave view)
//   busy            controller not idle
//   err             sticky core-timeout flag, cleared by iv_load
//   blk_cnt         blocks completed since last iv_load (wraps)
module aes128_mode_ctrl #(
  parameter int unsigned TIMEOUT = 31,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic [2:0]         mode,
  input  logic               iv_load,
  input  logic [127:0]       iv,
  aes128_mode_ctrl_if.slave  bus,
  output logic               busy,
  output logic               err,
  output logic [CNT_W-1:0]   blk_cnt
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned TMO_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUT
  } state_e;

  typedef enum logic [2:0] {
    M_ECB = 3'd0,
    M_CBC = 3'd1,
    M_CFB = 3'd2,
    M_OFB = 3'd3,
    M_CTR = 3'd4
  } mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  mode_e            mode_in_c;
  logic [BLK_W-1:0] chain_q, chain_d;
  logic [BLK_W-1:0] din_q, din_d;
  logic [BLK_W-1:0] core_din_q, core_din_d;
  logic [BLK_W-1:0] dout_q, dout_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q;
  logic             in_ready_c;

  // Unused mode encodings collapse to ECB at load time.
  always_comb begin
    mode_in_c = M_ECB;
    if (mode <= 3'd4) begin
      mode_in_c = mode_e'(mode);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= M_ECB;
      chain_q    <= '0;
      din_q      <= '0;
      core_din_q <= '0;
      dout_q     <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      chain_q    <= chain_d;
      din_q      <= din_d;
      core_din_q <= core_din_d;
      dout_q     <= dout_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      armed_q    <= 1'b1;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    chain_d    = chain_q;
    din_d      = din_q;
    core_din_d = core_din_q;
    dout_d     = dout_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    in_ready_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        // armed_q keeps in_ready low while reset is asserted and for the
        // first clock after release.
        in_ready_c = armed_q & bus.core_ready & ~iv_load;
        if (iv_load) begin
          chain_d = iv;
          mode_d  = mode_in_c;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (bus.in_valid && in_ready_c) begin
          din_d   = bus.din;
          state_d = S_START;
          case (mode_q)
            M_CBC:               core_din_d = bus.din ^ chain_q;
            M_CFB, M_OFB, M_CTR: core_din_d = chain_q;
            default:             core_din_d = bus.din;
          endcase
        end
      end

      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.core_ready) begin
          case (mode_q)
            M_CFB, M_OFB, M_CTR: dout_d = bus.core_dout ^ din_q;
            default:             dout_d = bus.core_dout;
          endcase
          case (mode_q)
            M_CBC:   chain_d = bus.core_dout;
            M_CFB:   chain_d = bus.core_dout ^ din_q;
            M_OFB:   chain_d = bus.core_dout;
            M_CTR:   chain_d = chain_q + BLK_W'(1);
            default: chain_d = chain_q;
          endcase
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_OUT;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          // Core never completed: drop the block, keep chain and count.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: flags come straight from the state register.
  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = (state_q == S_OUT);
  assign bus.dout       = dout_q;
  assign bus.core_start = (state_q == S_START);
  assign bus.core_din   = core_din_q;
  assign busy           = (state_q != S_IDLE);
  assign err            = err_q;
  assign blk_cnt        = cnt_q;

endmodule

// File: tb/tb_aes128_mode_ctrl.sv
// Bench for aes128_mode_ctrl: stand-in cipher core with an 11-cycle sequence,
// table of two-block vectors per mode, scoreboard queue of expected dout,
// plus hand-written latency, backpressure, timeout, iv_load and reset cases.
`timescale 1ns/1ps
module tb_aes128_mode_ctrl;

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ONES    = {128{1'b1}};
  localparam logic [127:0] VA      = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] VB      = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] VC      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VD      = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CIV     = 128'h0000000000000000ffffffffffffffff;
  localparam logic [127:0] CIV_P1  = 128'h00000000000000010000000000000000;

  logic         clk_sys = 1'b0;
  logic         rst_n;
  logic [2:0]   mode;
  logic         iv_load;
  logic [127:0] iv;
  logic         busy;
  logic         err;
  logic [31:0]  blk_cnt;

  aes128_mode_ctrl_if bus_if ();

  aes128_mode_ctrl #(.TIMEOUT(31), .CNT_W(32)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .mode    (mode),
    .iv_load (iv_load),
    .iv      (iv),
    .bus     (bus_if.slave),
    .busy    (busy),
    .err     (err),
    .blk_cnt (blk_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // Stand-in cipher: returns the FIPS-197 pair for its plaintext, otherwise
  // a fixed keyed permutation-like mix.
  function automatic logic [127:0] core_fn(input logic [127:0] x);
    logic [127:0] r;
    if (x == FIPS_PT) return FIPS_CT;
    r = {x[100:0], x[127:101]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    return r + {x[63:0], x[127:64]};
  endfunction

  // Core model: ready drops after start, result and ready return 11 cycles
  // after the start cycle. core_block masks ready (busy elsewhere / hung).
  logic         core_rdy_q;
  logic [3:0]   core_cnt_q;
  logic [127:0] core_in_q;
  logic [127:0] core_res_q;
  logic         core_block;

  assign bus_if.core_ready = core_rdy_q & ~core_block;
  assign bus_if.core_dout  = core_res_q;

  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      core_rdy_q <= 1'b1;
      core_cnt_q <= 4'd0;
      core_in_q  <= '0;
      core_res_q <= '0;
    end else if (bus_if.core_start) begin
      core_rdy_q <= 1'b0;
      core_cnt_q <= 4'd10;
      core_in_q  <= bus_if.core_din;
      core_res_q <= 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    end else if (core_cnt_q != 4'd0) begin
      core_cnt_q <= core_cnt_q - 4'd1;
      if (core_cnt_q == 4'd1) begin
        core_rdy_q <= 1'b1;
        core_res_q <= core_fn(core_in_q);
      end
    end
  end

  int unsigned    n_checks = 0;
  int unsigned    n_errors = 0;
  logic [127:0]   exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted result is compared with the oldest expectation.
  always @(negedge clk_sys) begin
    logic [127:0] e;
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got dout=%h with no result expected", bus_if.dout);
      end else begin
        e = exp_q.pop_front();
        check("dout", bus_if.dout, e);
      end
    end
  end

  task automatic load_iv(input logic [2:0] m, input logic [127:0] v);
    @(negedge clk_sys);
    iv_load = 1'b1;
    mode    = m;
    iv      = v;
    @(negedge clk_sys);
    iv_load = 1'b0;
  endtask

  task automatic send_block(input string name, input logic [127:0] d, input logic [127:0] e);
    int n = 0;
    @(negedge clk_sys);
    bus_if.in_valid = 1'b1;
    bus_if.din      = d;
    #1;
    while (!bus_if.in_ready && n < 100) begin
      @(negedge clk_sys);
      #1;
      n++;
    end
    if (!bus_if.in_ready) begin
      check_bit({name, "_accept_timeout"}, bus_if.in_ready, 1'b1);
    end else begin
      exp_q.push_back(e);
    end
    @(negedge clk_sys);
    bus_if.in_valid = 1'b0;
  endtask

  // Wait for the scoreboard to empty, then settle into IDLE.
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_drain_timeout"}, 128'(exp_q.size()), 128'(0));
      exp_q.delete();
    end
    @(negedge clk_sys);
  endtask

  typedef struct {
    string        name;
    logic [2:0]   mode;
    logic [127:0] iv;
    logic [127:0] d0;
    logic [127:0] d1;
    logic [127:0] e0;
    logic [127:0] e1;
  } vec_t;

  vec_t tv[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    int           viol;
    int           n;
    logic [127:0] held;
    logic [127:0] last_ct;

    tv[0] = '{"ecb",      3'd0, VA,      FIPS_PT, VB,      FIPS_CT,             core_fn(VB)};
    tv[1] = '{"cbc",      3'd1, '0,      FIPS_PT, FIPS_PT, FIPS_CT,             core_fn(FIPS_PT ^ FIPS_CT)};
    tv[2] = '{"cfb",      3'd2, VA,      VB,      VC,      core_fn(VA) ^ VB,    core_fn(core_fn(VA) ^ VB) ^ VC};
    tv[3] = '{"ofb",      3'd3, VD,      VB,      VC,      core_fn(VD) ^ VB,    core_fn(core_fn(VD)) ^ VC};
    tv[4] = '{"ctr_wrap", 3'd4, ONES,    '0,      '0,      core_fn(ONES),       core_fn('0)};
    tv[5] = '{"ctr",      3'd4, CIV,     VB,      VC,      core_fn(CIV) ^ VB,   core_fn(CIV_P1) ^ VC};
    tv[6] = '{"mode5",    3'd5, VA,      VC,      VD,      core_fn(VC),         core_fn(VD)};
    tv[7] = '{"mode7",    3'd7, VB,      VB,      VA,      core_fn(VB),         core_fn(VA)};

    rst_n            = 1'b0;
    mode             = 3'd0;
    iv_load          = 1'b0;
    iv               = '0;
    bus_if.in_valid  = 1'b0;
    bus_if.din       = '0;
    bus_if.out_ready = 1'b1;
    core_block       = 1'b0;

    // Reset values
    repeat (3) @(negedge clk_sys);
    check_bit("rst_in_ready", bus_if.in_ready, 1'b0);
    check_bit("rst_out_valid", bus_if.out_valid, 1'b0);
    check_bit("rst_core_start", bus_if.core_start, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check("rst_blk_cnt", 128'(blk_cnt), 128'(0));
    check("rst_dout", bus_if.dout, '0);
    check("rst_core_din", bus_if.core_din, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // FIPS-197 ECB with cycle-exact latency
    load_iv(3'd0, '0);
    @(negedge clk_sys);
    bus_if.in_valid = 1'b1;
    bus_if.din      = FIPS_PT;
    #1;
    check_bit("lat_in_ready_c0", bus_if.in_ready, 1'b1);
    exp_q.push_back(FIPS_CT);
    @(negedge clk_sys);
    bus_if.in_valid = 1'b0;
    check_bit("lat_core_start_c1", bus_if.core_start, 1'b1);
    check("lat_core_din_c1", bus_if.core_din, FIPS_PT);
    repeat (6) @(negedge clk_sys);
    check("lat_core_din_c7", bus_if.core_din, FIPS_PT);
    check_bit("lat_core_start_c7", bus_if.core_start, 1'b0);
    check_bit("lat_in_ready_c7", bus_if.in_ready, 1'b0);
    check_bit("lat_busy_c7", busy, 1'b1);
    repeat (5) @(negedge clk_sys);
    check_bit("lat_out_valid_c12", bus_if.out_valid, 1'b0);
    @(negedge clk_sys);
    check_bit("lat_out_valid_c13", bus_if.out_valid, 1'b1);
    check("lat_dout_c13", bus_if.dout, FIPS_CT);
    drain("lat");
    check("lat_blk_cnt", 128'(blk_cnt), 128'(1));

    // Mode vector table: two chained blocks per entry
    for (int i = 0; i < 8; i++) begin
      load_iv(tv[i].mode, tv[i].iv);
      check($sformatf("%s_blk_cnt_cleared", tv[i].name), 128'(blk_cnt), 128'(0));
      send_block(tv[i].name, tv[i].d0, tv[i].e0);
      drain(tv[i].name);
      send_block(tv[i].name, tv[i].d1, tv[i].e1);
      drain(tv[i].name);
      check($sformatf("%s_blk_cnt", tv[i].name), 128'(blk_cnt), 128'(2));
    end

    // iv_load and in_valid together: iv_load wins, block uses the new chain
    load_iv(3'd1, VA);
    @(negedge clk_sys);
    iv_load         = 1'b1;
    mode            = 3'd1;
    iv              = VB;
    bus_if.in_valid = 1'b1;
    bus_if.din      = VC;
    #1;
    check_bit("ivld_same_in_ready", bus_if.in_ready, 1'b0);
    @(negedge clk_sys);
    iv_load = 1'b0;
    #1;
    check_bit("ivld_next_in_ready", bus_if.in_ready, 1'b1);
    exp_q.push_back(core_fn(VC ^ VB));
    @(negedge clk_sys);
    bus_if.in_valid = 1'b0;
    drain("ivld_same");
    check("ivld_same_blk_cnt", 128'(blk_cnt), 128'(1));
    last_ct = core_fn(VC ^ VB);

    // Core busy from elsewhere: no acceptance in IDLE
    @(negedge clk_sys);
    core_block      = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.din      = VD;
    viol = 0;
    repeat (5) begin
      @(negedge clk_sys);
      if (bus_if.in_ready || busy || bus_if.core_start) viol++;
    end
    check("core_busy_no_accept", 128'(viol), 128'(0));
    core_block = 1'b0;
    exp_q.push_back(core_fn(VD ^ last_ct));
    @(negedge clk_sys);
    bus_if.in_valid = 1'b0;
    drain("core_busy");

    // Backpressure: result held, nothing else accepted or started
    load_iv(3'd0, '0);
    @(posedge clk_sys);
    #1 bus_if.out_ready = 1'b0;
    send_block("bp", VA, core_fn(VA));
    n = 0;
    while (!bus_if.out_valid && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check_bit("bp_out_valid", bus_if.out_valid, 1'b1);
    check("bp_dout", bus_if.dout, core_fn(VA));
    held = bus_if.dout;
    bus_if.in_valid = 1'b1;
    bus_if.din      = VB;
    viol = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (!bus_if.out_valid || bus_if.dout !== held || bus_if.in_ready || bus_if.core_start) viol++;
    end
    check("bp_hold_violations", 128'(viol), 128'(0));
    exp_q.push_back(core_fn(VB));
    @(posedge clk_sys);
    #1 bus_if.out_ready = 1'b1;
    n = 0;
    @(negedge clk_sys);
    while (!(busy && !bus_if.out_valid) && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    bus_if.in_valid = 1'b0;
    check_bit("bp_second_started", bus_if.core_start, 1'b1);
    drain("bp");
    check("bp_blk_cnt", 128'(blk_cnt), 128'(2));

    // Core hang: timeout sets err, no output, count kept
    load_iv(3'd0, '0);
    send_block("tmo_pre", VA, core_fn(VA));
    drain("tmo_pre");
    @(negedge clk_sys);
    bus_if.in_valid = 1'b1;
    bus_if.din      = VB;
    @(negedge clk_sys);
    bus_if.in_valid = 1'b0;
    core_block      = 1'b1;
    repeat (30) @(negedge clk_sys);
    check_bit("tmo_err_early", err, 1'b0);
    check_bit("tmo_busy_early", busy, 1'b1);
    repeat (2) @(negedge clk_sys);
    check_bit("tmo_err_set", err, 1'b1);
    check_bit("tmo_idle", busy, 1'b0);
    check("tmo_blk_cnt", 128'(blk_cnt), 128'(1));
    core_block = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_bit("tmo_err_sticky", err, 1'b1);
    load_iv(3'd0, '0);
    check_bit("tmo_err_cleared", err, 1'b0);
    check("tmo_blk_cnt_cleared", 128'(blk_cnt), 128'(0));

    // iv_load during WAIT is ignored
    load_iv(3'd4, VC);
    send_block("ivwait", VA, core_fn(VC) ^ VA);
    repeat (3) @(negedge clk_sys);
    check_bit("ivwait_busy", busy, 1'b1);
    iv_load = 1'b1;
    mode    = 3'd0;
    iv      = VD;
    @(negedge clk_sys);
    iv_load = 1'b0;
    drain("ivwait");
    check("ivwait_blk_cnt", 128'(blk_cnt), 128'(1));
    send_block("ivwait2", VB, core_fn(VC + 128'd1) ^ VB);
    drain("ivwait2");
    check("ivwait2_blk_cnt", 128'(blk_cnt), 128'(2));

    // Reset during WAIT: in-flight block discarded, core not restarted
    @(negedge clk_sys);
    bus_if.in_valid = 1'b1;
    bus_if.din      = VD;
    @(negedge clk_sys);
    bus_if.in_valid = 1'b0;
    repeat (4) @(negedge clk_sys);
    check_bit("mid_rst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_in_ready", bus_if.in_ready, 1'b0);
    check_bit("mid_rst_out_valid", bus_if.out_valid, 1'b0);
    check_bit("mid_rst_core_start", bus_if.core_start, 1'b0);
    check_bit("mid_rst_busy", busy, 1'b0);
    check("mid_rst_blk_cnt", 128'(blk_cnt), 128'(0));
    check("mid_rst_dout", bus_if.dout, '0);
    check("mid_rst_core_din", bus_if.core_din, '0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    viol = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (bus_if.core_start || bus_if.out_valid || busy) viol++;
    end
    check("mid_rst_quiet", 128'(viol), 128'(0));
    // Mode and chain back to ECB / zero after reset
    send_block("post_rst", FIPS_PT, FIPS_CT);
    drain("post_rst");
    check("post_rst_blk_cnt", 128'(blk_cnt), 128'(1));

    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
